// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one n_REG storage register among N_REQ writers.
// Each write runs IDLE -> LOAD -> ACK, with all outputs registered.
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   CLOCK,
  input  logic                   Clear_n,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] D_in,
  output logic [N_REQ-1:0]       Grant,
  output logic                   Load,
  output logic [WIDTH-1:0]       D_out,
  output logic [N_REQ-1:0]       Ack,
  output logic                   Busy,
  output logic [7:0]             Count
);

  localparam int LW = $clog2(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [LW-1:0]    TOP = LW'(N_REQ - 1);

  logic [1:0]    state;
  logic [LW-1:0] last;
  logic [LW-1:0] owner;
  logic [LW-1:0] win;
  logic          found;
  int            idx;

  // Search starts one past the last served requester and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && Req[idx[LW-1:0]]) begin
        found = 1'b1;
        win   = idx[LW-1:0];
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!Clear_n) begin
      state <= IDLE;
      last  <= TOP;
      owner <= '0;
      Grant <= '0;
      Load  <= 1'b0;
      D_out <= '0;
      Ack   <= '0;
      Busy  <= 1'b0;
      Count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            Grant <= ONE << win;
            D_out <= D_in[int'(win)*WIDTH +: WIDTH];
            owner <= win;
            Load  <= 1'b1;
            Busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          Load  <= 1'b0;
          Ack   <= Grant;
          state <= ACK;
        end
        ACK: begin
          last  <= owner;
          Count <= Count + 8'd1;
          Grant <= '0;
          Ack   <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Grant <= '0;
          Load  <= 1'b0;
          Ack   <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
